// File: rtl/pzhsbus_if.sv
// Upstream valid/ready/payload bundle for the pzhsbus family; the user picks the payload type.
interface pzhsbus_if #(
    parameter type PAYLOAD = logic
) ();
    logic   valid;
    logic   ready;
    PAYLOAD payload;

    modport master (output valid, output payload, input ready);
    modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/pzhsbus_credit_counter.sv
// Credit bookkeeping for the credit transmitter: consume on push, refill on return,
// clamp at the receiver depth and latch any overflow until reset or clear.
module pzhsbus_credit_counter #(
    parameter int CREDITS         = 8,
    parameter int INITIAL_CREDITS = CREDITS,
    parameter int MAX_RETURN      = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_clear,
    input  logic                              i_push,
    input  logic [$clog2(MAX_RETURN+1)-1:0]   i_credit_return,
    output logic [$clog2(CREDITS+1)-1:0]      o_count,
    output logic                              o_overflow
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int RW = $clog2(MAX_RETURN + 1);
    // One bit of headroom above the wider operand so an over-return is visible before clamping.
    localparam int SW = ((RW > CW) ? RW : CW) + 1;

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic          overflow_next;
    logic [SW-1:0] sum;

    always_comb begin
        sum           = SW'(count_reg) - SW'(i_push) + SW'(i_credit_return);
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (sum > SW'(CREDITS)) begin
            count_next    = CW'(CREDITS);
            overflow_next = 1'b1;
        end else begin
            count_next = sum[CW-1:0];
        end
        if (i_credit_return > RW'(MAX_RETURN)) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count_reg    <= CW'(INITIAL_CREDITS);
            overflow_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign o_count    = count_reg;
    assign o_overflow = overflow_reg;
endmodule

// File: rtl/pzhsbus_credit_tx.sv
// Credit-based transmitter: accepts upstream beats only while the remote receiver has
// buffer space, and forwards each accepted beat one cycle later with no backpressure.
module pzhsbus_credit_tx #(
    parameter type PAYLOAD         = logic,
    parameter int  CREDITS         = 8,
    parameter int  INITIAL_CREDITS = CREDITS,
    parameter int  MAX_RETURN      = 1,
    parameter int  FAST_CREDIT     = 0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_clear,
    pzhsbus_if.slave                          slave_if,
    output logic                              o_tx_valid,
    output PAYLOAD                            o_tx_payload,
    input  logic [$clog2(MAX_RETURN+1)-1:0]   i_credit_return,
    output logic [$clog2(CREDITS+1)-1:0]      o_credit_count,
    output logic                              o_credit_empty,
    output logic                              o_idle,
    output logic                              o_overflow
);
    localparam type COUNTER = logic [$clog2(CREDITS+1)-1:0];
    localparam type RETURN  = logic [$clog2(MAX_RETURN+1)-1:0];

    COUNTER count;
    RETURN  credit_return;
    logic   push;
    logic   tx_valid_reg;
    PAYLOAD tx_payload_reg;

    assign credit_return = i_credit_return;

    // With the bypass enabled a credit arriving this cycle may be spent this cycle.
    assign slave_if.ready = ~i_clear &
                            ((count != '0) | ((FAST_CREDIT != 0) & (credit_return != '0)));
    assign push = slave_if.valid & slave_if.ready;

    pzhsbus_credit_counter #(
        .CREDITS         (CREDITS),
        .INITIAL_CREDITS (INITIAL_CREDITS),
        .MAX_RETURN      (MAX_RETURN)
    ) u_counter (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_clear         (i_clear),
        .i_push          (push),
        .i_credit_return (credit_return),
        .o_count         (count),
        .o_overflow      (o_overflow)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_valid_reg   <= 1'b0;
            tx_payload_reg <= '0;
        end else if (i_clear) begin
            tx_valid_reg   <= 1'b0;
        end else begin
            tx_valid_reg <= push;
            if (push) begin
                tx_payload_reg <= slave_if.payload;
            end
        end
    end

    // A beat still sitting in the register when reset arrives is dropped, not emitted.
    assign o_tx_valid     = tx_valid_reg & ~i_rst;
    assign o_tx_payload   = tx_payload_reg;
    assign o_credit_count = count;
    assign o_credit_empty = (count == '0);
    assign o_idle         = (count == COUNTER'(CREDITS)) & ~o_tx_valid;
endmodule

// File: tb/tb_pzhsbus_credit_tx.sv
// Bench for pzhsbus_credit_tx: a slow-credit and a fast-credit instance driven in lockstep,
// checked against a credit-arithmetic model with a payload scoreboard.
module tb_pzhsbus_credit_tx;
    localparam int CREDITS    = 4;
    localparam int INIT       = 4;
    localparam int MAX_RETURN = 2;

    typedef logic [7:0] pl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s     = 1'b1;
    logic       clear_s   = 1'b0;
    logic       valid_s   = 1'b0;
    pl_t        payload_s = '0;
    logic [1:0] ret_s     = '0;

    logic       ready    [2];
    logic       tx_valid [2];
    pl_t        tx_pl    [2];
    logic [2:0] count    [2];
    logic       empty    [2];
    logic       idle     [2];
    logic       ovf      [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            pzhsbus_if #(.PAYLOAD(pl_t)) bus ();
            assign bus.valid   = valid_s;
            assign bus.payload = payload_s;
            assign ready[gi]   = bus.ready;

            pzhsbus_credit_tx #(
                .PAYLOAD         (pl_t),
                .CREDITS         (CREDITS),
                .INITIAL_CREDITS (INIT),
                .MAX_RETURN      (MAX_RETURN),
                .FAST_CREDIT     (gi)
            ) dut (
                .i_clk           (clk),
                .i_rst           (rst_s),
                .i_clear         (clear_s),
                .slave_if        (bus),
                .o_tx_valid      (tx_valid[gi]),
                .o_tx_payload    (tx_pl[gi]),
                .i_credit_return (ret_s),
                .o_credit_count  (count[gi]),
                .o_credit_empty  (empty[gi]),
                .o_idle          (idle[gi]),
                .o_overflow      (ovf[gi])
            );
        end
    endgenerate

    int  n_checks = 0;
    int  n_pass   = 0;
    int  beat_cnt [2];
    pl_t exp_q0 [$];
    pl_t exp_q1 [$];

    // Reference model: credits available, sticky error, beat expected this cycle.
    int m_count [2];
    bit m_ovf   [2];
    bit m_txv   [2];

    int  smp_ready [2];
    int  smp_count [2];
    int  smp_txv   [2];
    int  smp_pl    [2];
    int  smp_empty [2];
    int  smp_idle  [2];
    int  smp_ovf   [2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: every beat presented must match the oldest expected payload.
    initial begin
        beat_cnt[0] = 0;
        beat_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (tx_valid[k] === 1'b1) begin
                    pl_t e;
                    beat_cnt[k]++;
                    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                        n_checks++;
                        $display("FAIL beat_unexpected dut%0d: got beat 0x%02h expected none at %0t",
                                 k, tx_pl[k], $time);
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("payload dut%0d", k), int'(tx_pl[k]), int'(e));
                    end
                end
            end
        end
    end

    task automatic cycle(input logic rst, input logic clr, input logic v,
                         input pl_t p, input logic [1:0] r);
        rst_s = rst; clear_s = clr; valid_s = v; payload_s = p; ret_s = r;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bit exp_rdy;
            bit exp_txv;
            bit psh;
            int s;
            exp_rdy = !clr && (m_count[k] != 0 || (k == 1 && r != 0));
            exp_txv = m_txv[k] && !rst;
            smp_ready[k] = int'(ready[k]);
            smp_count[k] = int'(count[k]);
            smp_txv[k]   = int'(tx_valid[k]);
            smp_pl[k]    = int'(tx_pl[k]);
            smp_empty[k] = int'(empty[k]);
            smp_idle[k]  = int'(idle[k]);
            smp_ovf[k]   = int'(ovf[k]);
            if (!rst) check($sformatf("ready dut%0d", k), smp_ready[k], int'(exp_rdy));
            check($sformatf("count dut%0d", k), smp_count[k], m_count[k]);
            check($sformatf("empty dut%0d", k), smp_empty[k], int'(m_count[k] == 0));
            check($sformatf("idle dut%0d", k), smp_idle[k], int'(m_count[k] == CREDITS && !exp_txv));
            check($sformatf("overflow dut%0d", k), smp_ovf[k], int'(m_ovf[k]));
            check($sformatf("tx_valid dut%0d", k), smp_txv[k], int'(exp_txv));
            if (rst || clr) begin
                m_count[k] = INIT;
                m_ovf[k]   = 1'b0;
                m_txv[k]   = 1'b0;
                if (rst) begin
                    if (k == 0) exp_q0.delete(); else exp_q1.delete();
                end
            end else begin
                psh = v && exp_rdy;
                s = m_count[k] - int'(psh) + int'(r);
                if (s > CREDITS) begin
                    m_count[k] = CREDITS;
                    m_ovf[k]   = 1'b1;
                end else begin
                    m_count[k] = s;
                end
                if (int'(r) > MAX_RETURN) m_ovf[k] = 1'b1;
                m_txv[k] = psh;
                if (psh) begin
                    if (k == 0) exp_q0.push_back(p); else exp_q1.push_back(p);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, b1;
        for (int k = 0; k < 2; k++) begin
            m_count[k] = INIT; m_ovf[k] = 1'b0; m_txv[k] = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 8'h00, 0);
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("reset count", smp_count[0], INIT);
        check("reset payload", smp_pl[0], 0);
        check("reset idle", smp_idle[1], 1);
        check("reset ready", smp_ready[0], 1);

        // Exhaustion: valid held high with no returns.
        b0 = beat_cnt[0]; b1 = beat_cnt[1];
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, pl_t'(8'h10 + i), 0);
        check("exhaust beats dut0", beat_cnt[0] - b0, 4);
        check("exhaust beats dut1", beat_cnt[1] - b1, 4);
        check("exhaust ready", smp_ready[0], 0);
        check("exhaust empty", smp_empty[0], 1);

        // Slow return from zero credits.
        cycle(0, 0, 0, 8'h00, 1);
        check("slow return ready same cycle", smp_ready[0], 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("slow return ready next cycle", smp_ready[0], 1);
        check("slow return count", smp_count[0], 1);

        // Fast bypass: spend a credit the same cycle it returns.
        cycle(0, 0, 1, 8'h11, 0);
        cycle(0, 0, 1, 8'h3C, 1);
        check("fast ready on return", smp_ready[1], 1);
        check("slow ready on return", smp_ready[0], 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("fast beat", smp_txv[1], 1);
        check("fast beat payload", smp_pl[1], 8'h3C);
        check("fast count", smp_count[1], 0);
        check("slow count", smp_count[0], 1);

        // Push and return together at count 2.
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 1, 8'h01, 0);
        cycle(0, 0, 1, 8'h02, 0);
        cycle(0, 0, 1, 8'hA5, 1);
        check("simul pre count", smp_count[0], 2);
        cycle(0, 0, 0, 8'h00, 0);
        check("simul count dut0", smp_count[0], 2);
        check("simul count dut1", smp_count[1], 2);
        check("simul payload", smp_pl[0], 8'hA5);

        // Overflow at full credits, sticky until clear.
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 0);
        check("ovf count", smp_count[0], CREDITS);
        check("ovf flag", smp_ovf[0], 1);
        cycle(0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("ovf sticky", smp_ovf[1], 1);
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("ovf cleared", smp_ovf[0], 0);
        check("ovf clear count", smp_count[0], INIT);

        // Reset the cycle after a push: the pending beat is dropped.
        cycle(0, 0, 1, 8'h77, 0);
        cycle(1, 0, 0, 8'h00, 0);
        check("reset drops beat", smp_txv[0], 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("post reset count", smp_count[0], INIT);
        check("post reset idle", smp_idle[0], 1);
        check("post reset ready", smp_ready[1], 1);

        // Randomised traffic; returns biased low so credits actually run out.
        for (int i = 0; i < 400; i++) begin
            int rr;
            logic [1:0] r;
            rr = $urandom_range(0, 15);
            r = (rr < 9) ? 2'd0 : (rr < 13) ? 2'd1 : (rr < 15) ? 2'd2 : 2'd3;
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
                  $urandom_range(0, 3) != 0, pl_t'($urandom), r);
        end
        cycle(0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("scoreboard drained dut0", exp_q0.size(), 0);
        check("scoreboard drained dut1", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pzhsbus_credit_tx.md
PZHSBUS_CREDIT_TX -- requirements
Module: pzhsbus_credit_tx

Interface
REQ-001 SHALL have parameter PAYLOAD, default logic: type of the transfer payload.
REQ-002 SHALL have parameter CREDITS, default 8: buffer depth of the remote receiver, and maximum credit count.
REQ-003 SHALL have parameter INITIAL_CREDITS, default CREDITS: credit count after reset or clear, legal range 0..CREDITS.
REQ-004 SHALL have parameter MAX_RETURN, default 1: maximum credits returned in one cycle.
REQ-005 SHALL have parameter FAST_CREDIT, default 0: when 1, credits returned this cycle are usable this cycle.
REQ-006 SHALL have localparam COUNTER = logic [$clog2(CREDITS+1)-1:0] and localparam RETURN = logic [$clog2(MAX_RETURN+1)-1:0].
REQ-007 SHALL use one clock and a synchronous, active-high reset:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
REQ-008 SHALL have the following ports:
- i_clear  in  1  synchronous clear.
- slave_if  pzhsbus_if.slave  PAYLOAD  upstream valid/ready/payload.
- o_tx_valid  out  1  one-cycle beat to the remote receiver.
- o_tx_payload  out  PAYLOAD  registered payload.
- i_credit_return  in  RETURN  credits freed by the receiver this cycle.
- o_credit_count  out  COUNTER  current credits.
- o_credit_empty  out  1  credit count is 0.
- o_idle  out  1  all credits home and no beat pending.
- o_overflow  out  1  sticky credit-overflow error.

Function
REQ-009 SHALL assert slave_if.ready = ~i_clear & (count != 0 | (FAST_CREDIT & i_credit_return != 0)).
REQ-010 SHALL define a push as slave_if.valid & slave_if.ready.
REQ-011 SHALL register each push with latency 1: o_tx_valid is high in the next cycle, o_tx_payload equals the pushed payload, and there is no backpressure from the receiver.
REQ-012 SHALL drive o_tx_valid low in any cycle that follows a cycle without a push; o_tx_payload holds its last value.
REQ-013 SHALL update the credit count as next count = count - push + i_credit_return, computed at width COUNTER+1.
REQ-014 SHALL handle a result above CREDITS by clamping the count to CREDITS and setting o_overflow, which stays set until reset or clear.
REQ-015 SHALL set o_overflow when i_credit_return exceeds MAX_RETURN, with the same clamp rule as REQ-014.
REQ-016 SHALL handle a push together with a return by applying both in the same cycle: at count=1 with push and return=1, the next count is 1.
REQ-017 SHALL, with FAST_CREDIT=0 and count=0, hold ready low even while a return arrives; ready rises in the next cycle.
REQ-018 SHALL drive o_credit_empty = (count == 0) and o_idle = (count == CREDITS) & ~o_tx_valid; both are combinational from registered state.
REQ-019 SHALL make i_clear take effect in the next cycle: count = INITIAL_CREDITS, o_tx_valid = 0, o_overflow = 0; returns and pushes in the clear cycle are ignored.
REQ-020 SHALL give i_rst priority over i_clear.

Reset
REQ-021 SHALL set, on i_rst: count = INITIAL_CREDITS, o_tx_valid = 0, o_overflow = 0, o_tx_payload = '0.
REQ-022 SHALL discard, on reset mid-operation, any beat pending in the output register; it is never emitted.
REQ-023 SHALL hold slave_if.ready at the value REQ-009 gives from the reset count in the first cycle after reset is released.

Structure
REQ-024 SHALL use no new shared package; COUNTER and RETURN are local, and PAYLOAD comes from the pzhsbus_if user.
REQ-025 SHALL implement credit arithmetic, clamp and overflow in one sub-module, pzhsbus_credit_counter, parameterised by CREDITS, INITIAL_CREDITS and MAX_RETURN.
REQ-026 SHALL implement the output register and handshake in the top module.

Verification
REQ-027 SHALL check credit exhaustion: CREDITS=4, valid held high, no returns -> exactly 4 beats on o_tx_valid, ready low afterwards, o_credit_empty=1.
REQ-028 SHALL check returns: from count 0, apply return=1 with FAST_CREDIT=0 -> ready=0 that cycle, ready=1 next cycle, count=1.
REQ-029 SHALL check the FAST_CREDIT bypass: FAST_CREDIT=1, count 0, return=1 with valid=1 -> push in the same cycle, beat next cycle, count stays 0.
REQ-030 SHALL check simultaneous events: count=2, push plus return=1 -> count 2, with payload 0xA5 on o_tx_payload one cycle later.
REQ-031 SHALL check overflow: count=CREDITS, return=1 -> count stays CREDITS, o_overflow=1 until i_clear, then count=INITIAL_CREDITS and o_overflow=0.
REQ-032 SHALL check reset mid-operation: i_rst in the cycle after a push -> no o_tx_valid beat, count=INITIAL_CREDITS, o_idle=1.
